// File: rtl/display_conv_scheduler.sv
`default_nettype none
// ============================================================================
// display_conv_scheduler: sequences the shared binary-to-BCD converter and
// time-multiplexes the latched result onto a 3-digit seven-segment display.
// Rev 1.0
// ============================================================================
module display_conv_scheduler #(
  parameter int VALUE_WIDTH  = 13,
  parameter int SCAN_DIV     = 65536,
  parameter int CONV_TIMEOUT = 64,
  parameter int BLANK_LZ     = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [VALUE_WIDTH-1:0] i_Value,
  input  logic                   i_Load,
  output logic                   o_ConvStart,
  output logic [VALUE_WIDTH-1:0] o_ConvBinary,
  input  logic [15:0]            i_ConvBCD,
  input  logic                   i_ConvDV,
  output logic                   o_Busy,
  output logic                   o_Error,
  output logic [7:0]             o_SevenSegment,
  output logic [2:0]             o_Enable
);

  localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_TO_W   = $clog2(CONV_TIMEOUT + 1);

  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(CONV_TIMEOUT - 1);

  localparam logic [7:0] c_SEG_BLANK = 8'b11111111;
  localparam logic [7:0] c_SEG_DASH  = 8'b11111101;

  localparam logic [1:0] c_DIG_HUNDREDS = 2'd0;
  localparam logic [1:0] c_DIG_TENS     = 2'd1;
  localparam logic [1:0] c_DIG_ONES     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DISP_BLANK = 2'd0,
    DISP_DASH  = 2'd1,
    DISP_VALUE = 2'd2
  } disp_t;

  state_t                   r_state;
  logic                     r_conv_start;
  logic [VALUE_WIDTH-1:0]   r_conv_binary;
  logic                     r_error;
  logic                     r_pending;
  logic [VALUE_WIDTH-1:0]   r_pending_value;
  logic [c_TO_W-1:0]        r_timeout;
  logic [15:0]              r_disp_bcd;
  disp_t                    r_disp_mode;

  logic [c_SCAN_W-1:0]      r_scan_cnt;
  logic [1:0]               r_digit_ptr;
  logic [2:0]               r_enable;
  logic [7:0]               r_segment;

  logic [3:0]               w_hund;
  logic [3:0]               w_tens;
  logic [3:0]               w_ones;
  logic [7:0]               w_seg_hund;
  logic [7:0]               w_seg_tens;
  logic [7:0]               w_seg_ones;
  logic [2:0]               w_slot_enable;
  logic [7:0]               w_slot_segment;
  logic [1:0]               w_next_ptr;

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b00000010;
      4'd1:    s = 8'b10011110;
      4'd2:    s = 8'b00100100;
      4'd3:    s = 8'b00001100;
      4'd4:    s = 8'b10011000;
      4'd5:    s = 8'b01001000;
      4'd6:    s = 8'b01000000;
      4'd7:    s = 8'b00011110;
      4'd8:    s = 8'b00000000;
      4'd9:    s = 8'b00011000;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  // Conversion sequencer; a load arriving while busy is parked as pending.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_conv_start    <= 1'b0;
      r_conv_binary   <= '0;
      r_error         <= 1'b0;
      r_pending       <= 1'b0;
      r_pending_value <= '0;
      r_timeout       <= '0;
      r_disp_bcd      <= '0;
      r_disp_mode     <= DISP_BLANK;
    end else begin
      r_conv_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Load || r_pending) begin
            r_conv_binary <= i_Load ? i_Value : r_pending_value;
            r_pending     <= 1'b0;
            r_conv_start  <= 1'b1;
            r_state       <= S_START;
          end
        end
        S_START: begin
          r_timeout <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_ConvDV) begin
            r_disp_bcd  <= i_ConvBCD;
            r_disp_mode <= DISP_VALUE;
            r_error     <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_timeout == c_TO_LAST) begin
            r_error     <= 1'b1;
            r_disp_mode <= DISP_DASH;
            r_state     <= S_IDLE;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_Load && (r_state != S_IDLE)) begin
        r_pending       <= 1'b1;
        r_pending_value <= i_Value;
      end
    end
  end

  always_comb begin
    w_hund     = r_disp_bcd[11:8];
    w_tens     = r_disp_bcd[7:4];
    w_ones     = r_disp_bcd[3:0];
    w_seg_hund = f_seg(w_hund);
    w_seg_tens = f_seg(w_tens);
    w_seg_ones = f_seg(w_ones);
    if (BLANK_LZ != 0) begin
      if (w_hund == 4'd0) w_seg_hund = c_SEG_BLANK;
      if ((w_hund == 4'd0) && (w_tens == 4'd0)) w_seg_tens = c_SEG_BLANK;
    end
    // Nonzero thousands cannot be shown on three digits, so it reads as overflow.
    if (r_disp_mode == DISP_BLANK) begin
      w_seg_hund = c_SEG_BLANK;
      w_seg_tens = c_SEG_BLANK;
      w_seg_ones = c_SEG_BLANK;
    end else if ((r_disp_mode == DISP_DASH) || (r_disp_bcd[15:12] != 4'd0)) begin
      w_seg_hund = c_SEG_DASH;
      w_seg_tens = c_SEG_DASH;
      w_seg_ones = c_SEG_DASH;
    end
  end

  always_comb begin
    w_slot_enable  = 3'b111;
    w_slot_segment = c_SEG_BLANK;
    w_next_ptr     = c_DIG_HUNDREDS;
    case (r_digit_ptr)
      c_DIG_HUNDREDS: begin
        w_slot_enable  = 3'b011;
        w_slot_segment = w_seg_hund;
        w_next_ptr     = c_DIG_TENS;
      end
      c_DIG_TENS: begin
        w_slot_enable  = 3'b101;
        w_slot_segment = w_seg_tens;
        w_next_ptr     = c_DIG_ONES;
      end
      c_DIG_ONES: begin
        w_slot_enable  = 3'b110;
        w_slot_segment = w_seg_ones;
        w_next_ptr     = c_DIG_HUNDREDS;
      end
      default: ;
    endcase
  end

  // Enable and segments update together only at slot boundaries.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_scan_cnt  <= '0;
      r_digit_ptr <= c_DIG_HUNDREDS;
      r_enable    <= 3'b111;
      r_segment   <= c_SEG_BLANK;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_ptr <= w_next_ptr;
      r_enable    <= w_slot_enable;
      r_segment   <= w_slot_segment;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign o_ConvStart    = r_conv_start;
  assign o_ConvBinary   = r_conv_binary;
  assign o_Busy         = (r_state != S_IDLE) | r_pending;
  assign o_Error        = r_error;
  assign o_SevenSegment = r_segment;
  assign o_Enable       = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_display_conv_scheduler.sv
`default_nettype none
// ============================================================================
// tb_display_conv_scheduler: randomized self-checking bench with a behavioural
// converter and a decimal display model. Rev 1.0
// ============================================================================
module tb_display_conv_scheduler;

  localparam int VW = 13;
  localparam int SD = 4;
  localparam int CT = 64;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [VW-1:0] i_Value = '0;
  logic          i_Load = 1'b0;
  logic [15:0]   i_ConvBCD;
  logic          i_ConvDV;
  logic          o_ConvStart;
  logic [VW-1:0] o_ConvBinary;
  logic          o_Busy;
  logic          o_Error;
  logic [7:0]    o_SevenSegment;
  logic [2:0]    o_Enable;

  int total = 0;
  int bad = 0;

  bit            conv_respond = 1'b1;
  int            conv_delay = 10;
  bit            use_override = 1'b0;
  logic [15:0]   override_bcd = '0;
  int            n_starts = 0;
  logic [VW-1:0] last_op = '0;
  int            conv_cnt = 0;

  display_conv_scheduler #(
    .VALUE_WIDTH (VW),
    .SCAN_DIV    (SD),
    .CONV_TIMEOUT(CT),
    .BLANK_LZ    (1)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .i_Value       (i_Value),
    .i_Load        (i_Load),
    .o_ConvStart   (o_ConvStart),
    .o_ConvBinary  (o_ConvBinary),
    .i_ConvBCD     (i_ConvBCD),
    .i_ConvDV      (i_ConvDV),
    .o_Busy        (o_Busy),
    .o_Error       (o_Error),
    .o_SevenSegment(o_SevenSegment),
    .o_Enable      (o_Enable)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'b00000010;
      1: return 8'b10011110;
      2: return 8'b00100100;
      3: return 8'b00001100;
      4: return 8'b10011000;
      5: return 8'b01001000;
      6: return 8'b01000000;
      7: return 8'b00011110;
      8: return 8'b00000000;
      9: return 8'b00011000;
      default: return 8'b11111111;
    endcase
  endfunction

  // Expected {hundreds, tens, ones} pattern for a displayed decimal value.
  function automatic logic [23:0] model_frame(input int v);
    logic [7:0] h, t, o;
    if (v > 999) return {3{8'b11111101}};
    h = (v < 100) ? 8'hFF : seg_of(v / 100);
    t = (v < 10) ? 8'hFF : seg_of((v / 10) % 10);
    o = seg_of(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [2:0] next_en(input logic [2:0] e);
    case (e)
      3'b011:  return 3'b101;
      3'b101:  return 3'b110;
      3'b110:  return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Behavioural converter: answers a start pulse after conv_delay cycles.
  initial begin
    i_ConvDV  = 1'b0;
    i_ConvBCD = '0;
    forever begin
      @(posedge Clk);
      #2;
      i_ConvDV = 1'b0;
      if (o_ConvStart === 1'b1) begin
        n_starts++;
        last_op  = o_ConvBinary;
        conv_cnt = conv_respond ? conv_delay : 0;
      end else if (conv_cnt > 0) begin
        conv_cnt--;
        if (conv_cnt == 0) begin
          i_ConvDV  = 1'b1;
          i_ConvBCD = use_override ? override_bcd : to_bcd(int'(last_op));
        end
      end
    end
  end

  task automatic load(input int v);
    i_Value = VW'(v);
    i_Load  = 1'b1;
    @(negedge Clk);
    i_Load  = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    int k;
    k = 0;
    to = 1'b0;
    while (o_Busy !== 1'b0 && k < 400) begin
      @(negedge Clk);
      k++;
    end
    if (o_Busy !== 1'b0) to = 1'b1;
  endtask

  task automatic do_conv(input int v, output bit to);
    load(v);
    wait_idle(to);
  endtask

  // Records the next three lit slots by digit position.
  task automatic capture_frame(output logic [23:0] fr, output logic [8:0] ens, output bit to);
    logic [2:0] prev;
    int got, waited;
    fr = 'x;
    ens = '0;
    to = 1'b0;
    got = 0;
    waited = 0;
    prev = o_Enable;
    while (got < 3 && !to) begin
      @(negedge Clk);
      waited++;
      if (o_Enable !== prev) begin
        prev = o_Enable;
        ens = {ens[5:0], o_Enable};
        case (o_Enable)
          3'b011:  fr[23:16] = o_SevenSegment;
          3'b101:  fr[15:8]  = o_SevenSegment;
          3'b110:  fr[7:0]   = o_SevenSegment;
          default: ;
        endcase
        got++;
      end
      if (waited > 20 * SD) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    int k;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (o_ConvStart !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", o_ConvStart); end
    total++; if (o_ConvBinary !== '0) begin bad++; $display("FAIL reset_binary: got %0d want 0", o_ConvBinary); end
    total++; if (o_Busy !== 1'b0 || o_Error !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b err=%b want 0 0", o_Busy, o_Error); end
    total++; if (o_Enable !== 3'b111 || o_SevenSegment !== 8'hFF) begin bad++; $display("FAIL reset_display: en=%b seg=%b want 111 11111111", o_Enable, o_SevenSegment); end
    Reset = 1'b0;
    k = 0;
    while (o_Enable === 3'b111 && k < 10 * SD) begin
      @(negedge Clk);
      k++;
    end
    total++; if (k != SD) begin bad++; $display("FAIL first_slot: lit after %0d cycles want %0d", k, SD); end
    total++; if (o_Enable !== 3'b011 || o_SevenSegment !== 8'hFF) begin bad++; $display("FAIL first_digit: en=%b seg=%b want 011 11111111", o_Enable, o_SevenSegment); end
  endtask

  task automatic test_basic();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    int k;
    conv_respond = 1'b1; conv_delay = 16; use_override = 1'b0;
    load(888);
    total++; if (o_ConvStart !== 1'b1) begin bad++; $display("FAIL start_latency: ConvStart=%b want 1", o_ConvStart); end
    total++; if (o_ConvBinary !== VW'(888)) begin bad++; $display("FAIL operand: got %0d want 888", o_ConvBinary); end
    k = 0;
    while (i_ConvDV !== 1'b1 && k < 100) begin
      @(negedge Clk);
      k++;
    end
    total++; if (k != 16) begin bad++; $display("FAIL dv_timing: dv after %0d want 16", k); end
    total++; if (o_Busy !== 1'b1) begin bad++; $display("FAIL busy_at_dv: got %b want 1", o_Busy); end
    @(negedge Clk);
    total++; if (o_Busy !== 1'b0) begin bad++; $display("FAIL busy_after_dv: got %b want 0", o_Busy); end
    capture_frame(fr, ens, to);
    total++; if (to) begin bad++; $display("FAIL scan_888: timed out got 1 want 0"); end
    total++; if (fr !== model_frame(888)) begin bad++; $display("FAIL frame_888: got %h want %h", fr, model_frame(888)); end
    total++; if (ens[5:3] !== next_en(ens[8:6]) || ens[2:0] !== next_en(ens[5:3])) begin bad++; $display("FAIL scan_order: got %b want rotation 011>101>110", ens); end
  endtask

  task automatic test_blanking();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    int vals[3] = '{7, 40, 305};
    conv_delay = 5;
    foreach (vals[i]) begin
      do_conv(vals[i], to);
      capture_frame(fr, ens, to);
      total++; if (fr !== model_frame(vals[i])) begin bad++; $display("FAIL lz_%0d: got %h want %h", vals[i], fr, model_frame(vals[i])); end
    end
  endtask

  task automatic test_overflow_and_invalid();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    conv_delay = 8;
    do_conv(1234, to);
    capture_frame(fr, ens, to);
    total++; if (fr !== {3{8'b11111101}}) begin bad++; $display("FAIL overflow: got %h want fdfdfd", fr); end
    total++; if (o_Error !== 1'b0) begin bad++; $display("FAIL overflow_err: got %b want 0", o_Error); end
    use_override = 1'b1; override_bcd = 16'h0A5F;
    do_conv(0, to);
    capture_frame(fr, ens, to);
    use_override = 1'b0;
    total++; if (fr !== {8'hFF, 8'b01001000, 8'hFF}) begin bad++; $display("FAIL invalid_digit: got %h want ff48ff", fr); end
  endtask

  task automatic test_pending();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    int s0;
    conv_delay = 20;
    s0 = n_starts;
    load(5);
    repeat (3) @(negedge Clk);
    load(6);
    repeat (2) @(negedge Clk);
    load(9);
    total++; if (o_Busy !== 1'b1) begin bad++; $display("FAIL pending_busy: got %b want 1", o_Busy); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL pending_idle: timed out got 1 want 0"); end
    total++; if (n_starts - s0 != 2) begin bad++; $display("FAIL pending_starts: got %0d want 2", n_starts - s0); end
    total++; if (last_op !== VW'(9)) begin bad++; $display("FAIL pending_operand: got %0d want 9", last_op); end
    capture_frame(fr, ens, to);
    total++; if (fr !== model_frame(9)) begin bad++; $display("FAIL pending_frame: got %h want %h", fr, model_frame(9)); end
  endtask

  task automatic test_timeout();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    conv_respond = 1'b0;
    load(321);
    repeat (CT) @(negedge Clk);
    total++; if (o_Error !== 1'b0) begin bad++; $display("FAIL timeout_early: err=%b want 0 at start+%0d", o_Error, CT); end
    @(negedge Clk);
    total++; if (o_Error !== 1'b1 || o_Busy !== 1'b0) begin bad++; $display("FAIL timeout: err=%b busy=%b want 1 0", o_Error, o_Busy); end
    capture_frame(fr, ens, to);
    total++; if (fr !== {3{8'b11111101}}) begin bad++; $display("FAIL timeout_dash: got %h want fdfdfd", fr); end
    conv_respond = 1'b1; conv_delay = 4;
    do_conv(3, to);
    total++; if (o_Error !== 1'b0) begin bad++; $display("FAIL error_clear: got %b want 0", o_Error); end
    conv_delay = CT;
    do_conv(456, to);
    capture_frame(fr, ens, to);
    total++; if (o_Error !== 1'b0 || fr !== model_frame(456)) begin bad++; $display("FAIL dv_last_cycle: err=%b frame=%h want 0 %h", o_Error, fr, model_frame(456)); end
    conv_delay = CT + 1;
    do_conv(654, to);
    repeat (4) @(negedge Clk);
    capture_frame(fr, ens, to);
    total++; if (o_Error !== 1'b1 || fr !== {3{8'b11111101}}) begin bad++; $display("FAIL dv_too_late: err=%b frame=%h want 1 fdfdfd", o_Error, fr); end
  endtask

  task automatic test_random();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    int v;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(10, 99);
        2:       v = $urandom_range(100, 999);
        default: v = $urandom_range(0, 8191);
      endcase
      conv_delay = $urandom_range(1, 60);
      do_conv(v, to);
      capture_frame(fr, ens, to);
      total++; if (to || o_Error !== 1'b0 || fr !== model_frame(v)) begin bad++; $display("FAIL random_%0d: to=%b err=%b frame=%h want 0 0 %h", v, to, o_Error, fr, model_frame(v)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] fr;
    logic [8:0] ens;
    bit to;
    int s0;
    conv_delay = 30;
    load(77);
    repeat (4) @(negedge Clk);
    load(55);
    s0 = n_starts;
    Reset = 1'b1;
    #1;
    total++; if (o_Busy !== 1'b0 || o_Error !== 1'b0 || o_ConvStart !== 1'b0 || o_ConvBinary !== '0) begin bad++; $display("FAIL async_reset: busy=%b err=%b start=%b bin=%0d want 0 0 0 0", o_Busy, o_Error, o_ConvStart, o_ConvBinary); end
    total++; if (o_Enable !== 3'b111 || o_SevenSegment !== 8'hFF) begin bad++; $display("FAIL async_reset_disp: en=%b seg=%b want 111 11111111", o_Enable, o_SevenSegment); end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    total++; if (n_starts != s0 || o_Busy !== 1'b0) begin bad++; $display("FAIL reset_discard: starts=%0d busy=%b want 0 0", n_starts - s0, o_Busy); end
    capture_frame(fr, ens, to);
    total++; if (fr !== {3{8'hFF}}) begin bad++; $display("FAIL stale_dv: got %h want ffffff", fr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_overflow_and_invalid();
    test_pending();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_conv_scheduler.md
Name: display_conv_scheduler

Overview:
- Sequences the shared Binary_to_BCD converter and the 3-digit multiplexed seven-segment display.
- Accepts binary values from any producer via a load strobe. Starts one conversion at a time and latches the BCD result.
- Time-multiplexes hundreds/tens/ones onto the shared segment bus. Replaces free-running converter start and clock-derived strobes with a single-clock-domain controller.

Parameters:
- VALUE_WIDTH, 13, width of binary input and converter binary port.
- SCAN_DIV, 65536, Clk cycles per digit slot (≥2).
- CONV_TIMEOUT, 64, max Clk cycles waiting for converter DV before abort (≥VALUE_WIDTH+4).
- BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens.

Ports:
- Clk  in  1  system clock
- Reset  in  1  async active-high reset
- i_Value  in  VALUE_WIDTH  binary value to display
- i_Load  in  1  1-cycle strobe: capture i_Value for display
- o_ConvStart  out  1  1-cycle start pulse to converter
- o_ConvBinary  out  VALUE_WIDTH  registered operand to converter, stable from start to DV
- i_ConvBCD  in  16  converter BCD result, 4 digits, [3:0] = ones
- i_ConvDV  in  1  converter result-valid pulse
- o_Busy  out  1  conversion in flight or pending
- o_Error  out  1  sticky until next successful latch: last conversion timed out
- o_SevenSegment  out  8  active-low segments, [7]=a … [1]=g, [0]=dp
- o_Enable  out  3  active-low digit enables, [2]=hundreds, [0]=ones

Behaviour:
- Reset (async, active-high): state IDLE; o_ConvStart=0, o_ConvBinary=0, o_Busy=0, o_Error=0; o_Enable=3'b111; o_SevenSegment=8'hFF; display register = blank; pending flag=0; scan counter=0; digit pointer=hundreds.
- Conversion FSM: IDLE -> START -> WAIT -> IDLE.
- IDLE: if i_Load or pending, register operand (i_Load value wins over pending value), clear pending, go START.
- START: o_ConvStart=1 for exactly this cycle; load timeout counter; go WAIT.
- WAIT: on i_ConvDV, latch i_ConvBCD into display register, clear o_Error, go IDLE. If timeout counter reaches CONV_TIMEOUT without DV, set o_Error, set display to "---", go IDLE.
- Latency: i_Load at cycle n -> o_ConvStart at n+1 (from IDLE). DV at cycle m -> display register updated at m+1.
- i_Load while not IDLE: capture value into pending register and set pending; later loads overwrite it (last wins). Exactly one follow-up conversion runs after the current one completes.
- o_Busy = (state != IDLE) | pending.
- i_ConvDV in IDLE/START: ignored.
- Overflow: if latched thousands digit ≠ 0, display "---".
- Any BCD digit >9: that digit shows blank.
- Scan: counter wraps at SCAN_DIV-1; on wrap, advance pointer hundreds -> tens -> ones -> hundreds, then register o_Enable and o_SevenSegment together in the same cycle. Enable codes: 011 hundreds, 101 tens, 110 ones. First digit lights at SCAN_DIV cycles after reset.
- Segment codes:
  - 0=00000010, 1=10011110, 2=00100100, 3=00001100, 4=10011000
  - 5=01001000, 6=01000000, 7=00011110, 8=00000000, 9=00011000
  - dash=11111101, blank=11111111
- Leading-zero blanking (BLANK_LZ=1): hundreds blank if 0; tens blank if hundreds and tens are both 0. Ones is never blanked.
- Display content changes only at digit-slot boundaries; no glitch mid-slot.
- Reset mid-conversion: FSM to IDLE immediately; pending discarded; late DV ignored.

Test Plan:
- Reset, SCAN_DIV=4, load 888, DV after 16 cycles with BCD 0x0888 -> ConvStart 1 cycle after load; enables 011/101/110 each show 00000000; o_Busy falls the cycle after DV.
- Load 7, BLANK_LZ=1 -> hundreds=11111111, tens=11111111, ones=00011110. Load 40 -> hundreds blank, tens=10011000, ones=00000010.
- Load 1234 (BCD 0x1234) -> all three digits 11111101; o_Error stays 0.
- Load 5, then 6 and 9 while WAIT -> exactly two ConvStart pulses; second operand = 9; final display shows "  9".
- Converter never asserts DV, CONV_TIMEOUT=64 -> o_Error=1 at cycle 65 after start; "---" shown; next good load clears o_Error.
- Assert Reset during WAIT, then deliver stale DV -> outputs return to reset values; display stays blank; no ConvStart.
